comp_mag_seq: RTL and testbench
===============================

// Module: comp_mag_seq
// PURPOSE
//  Parametrised digit-serial magnitude comparator; next generation of comp_gt8.
//  Compares two W-bit operands D bits per clock, MSB digit first.
//  Terminates early at the first differing digit and reports gt/eq/lt.
//  Uses a start/ready/done handshake. Serves as the shared compare engine for
//  score and paddle/ball coordinate checks, where wide operands must not form
//  a long combinational carry chain.
// PARAMETERS
//  W  16  operand width in bits; W >= 1
//  D  4   digit width in bits compared per cycle; 1 <= D <= W, W % D == 0
//         (elaboration $error otherwise)
// PORTS
//  clk      in   1  system clock, rising edge
//  reset_n  in   1  asynchronous reset, active low
//  start    in   1  request; accepted only on an edge where ready=1
//  a        in   W  operand A; sampled on the accepting edge only
//  b        in   W  operand B; sampled on the accepting edge only
//  ready    out  1  engine idle, start will be accepted (combinational from state)
//  done     out  1  registered single-cycle pulse: gt/eq/lt updated
//  gt       out  1  registered; A > B
//  eq       out  1  registered; A == B
//  lt       out  1  registered; A < B
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=IDLE, ready=1, done=0, gt=eq=lt=0.
//    Internal shift registers and counter clear. Any operation in flight is
//    discarded, and no done pulse follows.
//  - FSM, two states:
//    - IDLE: ready=1. On start=1, latch a/b into shift regs sa/sb, set
//      cnt=W/D, go to RUN.
//    - RUN: ready=0. Each edge compares the top digits sa[W-1 -: D] and
//      sb[W-1 -: D]:
//      - digits differ: gt = (digA > digB), lt = !gt, eq = 0, done = 1,
//        go to IDLE;
//      - digits equal, cnt == 1: eq = 1, gt = lt = 0, done = 1, go to IDLE;
//      - digits equal, cnt > 1: shift sa/sb left by D (zero fill),
//        cnt = cnt - 1, stay in RUN.
//  - Latency: start accepted on edge E0, first differing digit is index k
//    (1 = MSB digit). Results update and done rises on edge E0+k; done is
//    high for exactly one cycle. Worst case (equal operands) is k = W/D.
//  - gt/eq/lt are one-hot after the first completed compare. They hold their
//    value until the next completion and do NOT clear on start.
//  - start in RUN is ignored; no queuing.
//  - Back-to-back: in the done cycle the state is already IDLE and ready=1.
//    A start there is accepted, giving one result per k+1 cycles maximum.
//  - a/b changes after the accepting edge have no effect on the current result.
//  - D == W: single RUN cycle; done one edge after acceptance.
//  - cnt width is $clog2(W/D+1). Digit compare is an unsigned D-bit compare.
// CONFIGURATION
//  COMP_SIGNED_EN defined:
//    - Operands are two's complement.
//    - At latch, bit W-1 of both a and b is inverted before entering sa/sb;
//      the rest of the datapath is unchanged.
//    - Example: 16'h8000 (-32768) < 16'h7FFF.
//  COMP_SIGNED_EN undefined:
//    - Pure unsigned compare; no inversion logic is present.
//  Latency and handshake are identical in both builds.
// TESTING (W=16, D=4 unless stated)
//  1. Reset -> ready=1, done=0, gt=eq=lt=0.
//     Then a=2, b=1, start: done exactly 4 cycles after acceptance, gt=1.
//  2. a=16'h8000, b=16'h7FFF -> done after 1 cycle.
//     gt=1 when unsigned; lt=1 with COMP_SIGNED_EN.
//  3. a=b=16'h1234 -> eq=1 after 4 cycles.
//     Then a=101, b=100 -> gt=1; a=102, b=103 -> lt=1.
//  4. start held high in RUN, with a/b toggled mid-op -> ignored; result is
//     from the latched values.
//     New start in the done cycle -> accepted, next done k cycles later.
//  5. reset_n low in the 2nd RUN cycle -> outputs zero immediately, ready=1,
//     no done after release.
//  6. Variants D=16 (done 1 cycle after start) and D=1, W=8: a=8'h01, b=8'h00
//     -> gt after 8 cycles.
//     Random sweep against a behavioural a>b / a==b / a<b model.

Source files
------------

// File: rtl/comp_mag_seq.sv
// -----------------------------------------------------------------------------
// comp_mag_seq
// Digit-serial magnitude comparator. Compares two W-bit operands D bits per
// clock, most significant digit first, and stops at the first digit that
// differs. A start/ready/done handshake frames each compare. gt/eq/lt are
// registered and hold until the next completion.
//
// Build option:
//   COMP_SIGNED_EN - operands are two's complement. The sign bit of both
//                    operands is inverted at load time, which maps signed
//                    order onto unsigned order. The rest of the datapath is
//                    unchanged, so latency is the same in both builds.
// -----------------------------------------------------------------------------
module comp_mag_seq #(
    parameter int W = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done,
    output logic         gt,
    output logic         eq,
    output logic         lt
);

    localparam int N  = W / D;           // digits per operand
    localparam int CW = $clog2(N + 1);   // counter holds W/D down to 1

    // Reject geometries where the digits do not tile the operand exactly.
    generate
        if (W < 1 || D < 1 || D > W || (W % D) != 0) begin : g_bad_params
            $error("comp_mag_seq: need W >= 1, 1 <= D <= W and W %% D == 0 (W=%0d D=%0d)", W, D);
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    logic [W-1:0]   sa;
    logic [W-1:0]   sb;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   load_a;
    logic [W-1:0]   load_b;
    logic [D-1:0]   dig_a;
    logic [D-1:0]   dig_b;

`ifdef COMP_SIGNED_EN
    // Flipping the sign bit turns two's-complement order into unsigned order.
    localparam logic [W-1:0] SIGN_FLIP = W'(1) << (W - 1);
    assign load_a = a ^ SIGN_FLIP;
    assign load_b = b ^ SIGN_FLIP;
`else
    assign load_a = a;
    assign load_b = b;
`endif

    // The digit under test is always the top D bits of each shift register.
    assign dig_a = sa[W-1 -: D];
    assign dig_b = sb[W-1 -: D];

    // Idle is the only state in which a new request is accepted.
    assign ready = (state == IDLE);

    // Handshake FSM, digit datapath and registered result flags.
    // NOTE: every register here, shift registers included, is assigned with <=
    // so all of them update from the same pre-edge values; the shift registers
    // are reset as well so no stale operand survives an aborted compare.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= load_a;
                        sb    <= load_b;
                        cnt   <= CW'(N);
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (dig_a != dig_b) begin
                        // First differing digit decides the result.
                        gt    <= (dig_a > dig_b);
                        lt    <= (dig_a < dig_b);
                        eq    <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (cnt == CW'(1)) begin
                        // Last digit matched too: operands are equal.
                        gt    <= 1'b0;
                        lt    <= 1'b0;
                        eq    <= 1'b1;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        sa    <= sa << D;
                        sb    <= sb << D;
                        cnt   <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comp_mag_seq.sv
// -----------------------------------------------------------------------------
// tb_comp_mag_seq
// Self-checking bench for comp_mag_seq. Three instances share clk/reset_n:
//   unit 0: W=16, D=4   unit 1: W=16, D=16   unit 2: W=8, D=1
// Expected latency and result come from a behavioural model: latency is the
// 1-based index of the first differing digit (W/D when equal), the result is
// a plain numeric compare (signed when COMP_SIGNED_EN is defined).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_comp_mag_seq;

    logic        clk;
    logic        reset_n;
    logic        start_v [3];
    logic [15:0] a_v     [3];
    logic [15:0] b_v     [3];
    logic [2:0]  ready_v;
    logic [2:0]  done_v;
    logic [2:0]  gt_v;
    logic [2:0]  eq_v;
    logic [2:0]  lt_v;

    int checks = 0;
    int errors = 0;

    localparam int UW [3] = '{16, 16, 8};
    localparam int UD [3] = '{4, 16, 1};

    comp_mag_seq #(.W(16), .D(4)) u_d4 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .ready(ready_v[0]), .done(done_v[0]), .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0])
    );

    comp_mag_seq #(.W(16), .D(16)) u_d16 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .ready(ready_v[1]), .done(done_v[1]), .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1])
    );

    comp_mag_seq #(.W(8), .D(1)) u_w8 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .a(a_v[2][7:0]), .b(b_v[2][7:0]),
        .ready(ready_v[2]), .done(done_v[2]), .gt(gt_v[2]), .eq(eq_v[2]), .lt(lt_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    function automatic int model_lat(input longint unsigned x, input longint unsigned y,
                                     input int w, input int d);
        longint unsigned m;
        m = (longint'(1) << d) - 1;
        for (int i = 1; i <= w / d; i++) begin
            if (((x >> (w - i * d)) & m) != ((y >> (w - i * d)) & m))
                return i;
        end
        return w / d;
    endfunction

    function automatic logic [2:0] model_res(input longint unsigned x, input longint unsigned y,
                                             input int w);
        longint sx;
        longint sy;
        sx = longint'(x);
        sy = longint'(y);
`ifdef COMP_SIGNED_EN
        if (x[w-1]) sx = sx - (longint'(1) << w);
        if (y[w-1]) sy = sy - (longint'(1) << w);
`endif
        if (sx > sy)  return 3'b100;
        if (sx == sy) return 3'b010;
        return 3'b001;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    // Present a request now and let the next rising edge accept it.
    task automatic issue(input int u, input logic [15:0] x, input logic [15:0] y);
        start_v[u] = 1'b1;
        a_v[u]     = x;
        b_v[u]     = y;
        @(posedge clk);
        #1;
        start_v[u] = 1'b0;
    endtask

    // Count edges until done; lat = -1 if the budget runs out.
    task automatic wait_done(input int u, input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            if (done_v[u]) begin
                lat = k;
                break;
            end
        end
    endtask

    function automatic logic [2:0] res_of(input int u);
        return {gt_v[u], eq_v[u], lt_v[u]};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset;
        int lat;
        reset_n = 1'b0;
        #12;
        checks++;
        if (ready_v !== 3'b111) begin
            errors++; $display("FAIL reset_ready: got %b expected 111", ready_v);
        end
        checks++;
        if ({done_v, gt_v, eq_v, lt_v} !== 12'h000) begin
            errors++; $display("FAIL reset_flags: done=%b gt=%b eq=%b lt=%b expected all 0", done_v, gt_v, eq_v, lt_v);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 16'd2, 16'd1);
        wait_done(0, 40, lat);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL t1_latency: got %0d expected 4", lat);
        end
        checks++;
        if (res_of(0) !== 3'b100) begin
            errors++; $display("FAIL t1_result: got %b expected 100", res_of(0));
        end
        @(posedge clk);
        #1;
        checks++;
        if (done_v[0] !== 1'b0) begin
            errors++; $display("FAIL t1_done_width: done still %b one cycle later, expected 0", done_v[0]);
        end
    endtask

    task automatic test_early_exit;
        int lat;
        issue(0, 16'h8000, 16'h7FFF);
        wait_done(0, 40, lat);
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL t2_latency: got %0d expected 1", lat);
        end
        checks++;
        if (res_of(0) !== model_res(64'h8000, 64'h7FFF, 16)) begin
            errors++; $display("FAIL t2_result: got %b expected %b", res_of(0), model_res(64'h8000, 64'h7FFF, 16));
        end
    endtask

    task automatic test_patterns;
        logic [15:0] xs [3] = '{16'h1234, 16'd101, 16'd102};
        logic [15:0] ys [3] = '{16'h1234, 16'd100, 16'd103};
        logic [2:0]  want [3] = '{3'b010, 3'b100, 3'b001};
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue(0, xs[i], ys[i]);
            wait_done(0, 40, lat);
            checks++;
            if (lat !== 4) begin
                errors++; $display("FAIL t3_latency[%0d]: got %0d expected 4", i, lat);
            end
            checks++;
            if (res_of(0) !== want[i]) begin
                errors++; $display("FAIL t3_result[%0d]: got %b expected %b", i, res_of(0), want[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] x  = 16'h1234;
        logic [15:0] y  = 16'h1239;
        logic [15:0] x2 = 16'hA000;
        logic [15:0] y2 = 16'h9FFF;
        int lat;
        // Start stays high through RUN while the operands wander.
        start_v[0] = 1'b1;
        a_v[0]     = x;
        b_v[0]     = y;
        @(posedge clk);
        #1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            a_v[0] = 16'($urandom);
            b_v[0] = 16'($urandom);
            @(posedge clk);
            #1;
            if (done_v[0]) begin
                lat = k;
                break;
            end
            checks++;
            if (ready_v[0] !== 1'b0) begin
                errors++; $display("FAIL t4_ready_in_run: got %b expected 0", ready_v[0]);
            end
        end
        checks++;
        if (lat !== model_lat(64'(x), 64'(y), 16, 4)) begin
            errors++; $display("FAIL t4_latency: got %0d expected %0d", lat, model_lat(64'(x), 64'(y), 16, 4));
        end
        checks++;
        if (res_of(0) !== model_res(64'(x), 64'(y), 16)) begin
            errors++; $display("FAIL t4_result: got %b expected %b", res_of(0), model_res(64'(x), 64'(y), 16));
        end
        checks++;
        if (ready_v[0] !== 1'b1) begin
            errors++; $display("FAIL t4_ready_in_done: got %b expected 1", ready_v[0]);
        end
        // Start is still high in the done cycle: the next pair is taken here.
        a_v[0] = x2;
        b_v[0] = y2;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        wait_done(0, 40, lat);
        checks++;
        if (lat !== model_lat(64'(x2), 64'(y2), 16, 4)) begin
            errors++; $display("FAIL t4_b2b_latency: got %0d expected %0d", lat, model_lat(64'(x2), 64'(y2), 16, 4));
        end
        checks++;
        if (res_of(0) !== model_res(64'(x2), 64'(y2), 16)) begin
            errors++; $display("FAIL t4_b2b_result: got %b expected %b", res_of(0), model_res(64'(x2), 64'(y2), 16));
        end
    endtask

    task automatic test_reset_in_run;
        issue(0, 16'h5555, 16'h5555);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ready_v[0], done_v[0], res_of(0)} !== 5'b10000) begin
            errors++; $display("FAIL t5_async_reset: ready/done/gt/eq/lt got %b expected 10000", {ready_v[0], done_v[0], res_of(0)});
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done_v[0] !== 1'b0 || ready_v[0] !== 1'b1) begin
                errors++; $display("FAIL t5_no_done_after_release: cycle %0d done=%b ready=%b expected 0/1", k, done_v[0], ready_v[0]);
            end
        end
    endtask

    task automatic test_variants;
        int lat;
        issue(1, 16'h0F0F, 16'h0F0E);
        wait_done(1, 40, lat);
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL t6_d16_latency: got %0d expected 1", lat);
        end
        checks++;
        if (res_of(1) !== 3'b100) begin
            errors++; $display("FAIL t6_d16_result: got %b expected 100", res_of(1));
        end
        issue(2, 16'h0001, 16'h0000);
        wait_done(2, 40, lat);
        checks++;
        if (lat !== 8) begin
            errors++; $display("FAIL t6_d1_latency: got %0d expected 8", lat);
        end
        checks++;
        if (res_of(2) !== 3'b100) begin
            errors++; $display("FAIL t6_d1_result: got %b expected 100", res_of(2));
        end
    endtask

    task automatic test_random_sweep;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] wmask;
        int lat;
        int elat;
        logic [2:0] eres;
        for (int u = 0; u < 3; u++) begin
            wmask = (UW[u] == 16) ? 16'hFFFF : 16'h00FF;
            for (int n = 0; n < 40; n++) begin
                x = 16'($urandom) & wmask;
                case ($urandom_range(0, 3))
                    0:       y = x;
                    1:       y = x ^ (16'(1) << $urandom_range(0, UW[u] - 1));
                    default: y = 16'($urandom) & wmask;
                endcase
                elat = model_lat(64'(x), 64'(y), UW[u], UD[u]);
                eres = model_res(64'(x), 64'(y), UW[u]);
                issue(u, x, y);
                wait_done(u, 40, lat);
                checks++;
                if (lat !== elat || res_of(u) !== eres) begin
                    errors++;
                    $display("FAIL sweep u%0d a=%h b=%h: latency %0d result %b, expected latency %0d result %b",
                             u, x, y, lat, res_of(u), elat, eres);
                end
            end
        end
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            start_v[u] = 1'b0;
            a_v[u]     = '0;
            b_v[u]     = '0;
        end
        test_reset;
        test_early_exit;
        test_patterns;
        test_back_to_back;
        test_reset_in_run;
        test_variants;
        test_random_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
